// File: rtl/reg_write_sequencer.sv
// Sequencing initiator for a two-entry register bank: accepts LOAD/MOVE/SWAP/CLEAR
// operations and generates the bank's write strobes, one register per cycle.
module reg_write_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic             op_dst,
    input  logic [WIDTH-1:0] op_imm,
    input  logic [WIDTH-1:0] temp1,
    input  logic [WIDTH-1:0] temp2,
    output logic [WIDTH-1:0] data_in,
    output logic             sel_in,
    output logic             enable_write,
    output logic             done
);
    // Handshake: an operation transfers on a rising clk edge where op_valid and
    // op_ready are both 1; while op_ready is 0 all request inputs are ignored.
    typedef enum logic [1:0] {IDLE, WR_A, WR_B, FIN} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         code_q, code_d;
    logic               dst_q, dst_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [WIDTH-1:0]   h0_q, h0_d;
    logic [WIDTH-1:0]   h1_q, h1_d;
    logic               op_ready_q, op_ready_d;
    logic               enable_write_q, enable_write_d;
    logic               sel_in_q, sel_in_d;
    logic [WIDTH-1:0]   data_in_q, data_in_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dst_d   = dst_q;
        imm_d   = imm_q;
        h0_d    = h0_q;
        h1_d    = h1_q;

        case (state_q)
            IDLE: begin
                if (op_ready_q && op_valid) begin
                    code_d  = op_code;
                    dst_d   = op_dst;
                    imm_d   = op_imm;
                    h0_d    = temp1;
                    h1_d    = temp2;
                    state_d = WR_A;
                end
            end
            WR_A: begin
                if (code_q == OP_SWAP || code_q == OP_CLEAR) state_d = WR_B;
                else                                         state_d = FIN;
            end
            WR_B:    state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and the next hold values, so
        // they appear registered in the cycle the FSM occupies that state.
        enable_write_d = 1'b0;
        sel_in_d       = 1'b0;
        data_in_d      = '0;
        if (state_d == WR_A) begin
            enable_write_d = 1'b1;
            case (code_d)
                OP_LOAD: begin
                    sel_in_d  = dst_d;
                    data_in_d = imm_d;
                end
                OP_MOVE: begin
                    sel_in_d  = dst_d;
                    data_in_d = dst_d ? h0_d : h1_d;
                end
                OP_SWAP: begin
                    sel_in_d  = 1'b0;
                    data_in_d = h1_d;
                end
                default: begin
                    sel_in_d  = 1'b0;
                    data_in_d = '0;
                end
            endcase
        end else if (state_d == WR_B) begin
            enable_write_d = 1'b1;
            sel_in_d       = 1'b1;
            data_in_d      = (code_d == OP_SWAP) ? h0_d : '0;
        end
        done_d     = (state_d == FIN);
        op_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            code_q         <= 2'b00;
            dst_q          <= 1'b0;
            imm_q          <= '0;
            h0_q           <= '0;
            h1_q           <= '0;
            op_ready_q     <= 1'b0;
            enable_write_q <= 1'b0;
            sel_in_q       <= 1'b0;
            data_in_q      <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            dst_q          <= dst_d;
            imm_q          <= imm_d;
            h0_q           <= h0_d;
            h1_q           <= h1_d;
            op_ready_q     <= op_ready_d;
            enable_write_q <= enable_write_d;
            sel_in_q       <= sel_in_d;
            data_in_q      <= data_in_d;
            done_q         <= done_d;
        end
    end

    assign op_ready     = op_ready_q;
    assign enable_write = enable_write_q;
    assign sel_in       = sel_in_q;
    assign data_in      = data_in_q;
    assign done         = done_q;
endmodule
